// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: read-side handshake between the byte FIFO and its serial drain.
interface fifo_uart_tx_if;
   logic       Fempty;
   logic [7:0] Fdata;
   logic       Ren;
   modport master (input Fempty, input Fdata, output Ren);
   modport slave (output Fempty, output Fdata, input Ren);
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains the byte FIFO into async serial frames (start, 8 data LSB first, optional even parity, stop).
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter bit PARITY_EN    = 1'b0
) (
   input  logic                  ck,
   input  logic                  rst,
   input  logic                  en,
   fifo_uart_tx_if.master        fifo,
   output logic                  txd,
   output logic                  busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PAR, STOP} state_t;
   state_t        state, state_n;
   logic [CW-1:0] baud_cnt, baud_cnt_n;
   logic [2:0]    bit_cnt, bit_cnt_n;
   logic [7:0]    shreg, shreg_n;
   logic          par, par_n, txd_n, ren_n, bit_end;
   assign bit_end = baud_cnt == CW'(CLKS_PER_BIT - 1);
   assign busy = state != IDLE;
   always_ff @(posedge ck)
      if (!rst) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par      <= 1'b0;
         txd      <= 1'b1;
         fifo.Ren <= 1'b0;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_cnt_n;
         bit_cnt  <= bit_cnt_n;
         shreg    <= shreg_n;
         par      <= par_n;
         txd      <= txd_n;
         fifo.Ren <= ren_n;
      end
   // txd is registered, so each state loads the level for the next bit at its boundary
   always_comb begin
      state_n    = state;
      baud_cnt_n = bit_end ? '0 : baud_cnt + CW'(1);
      bit_cnt_n  = bit_cnt;
      shreg_n    = shreg;
      par_n      = par;
      txd_n      = txd;
      ren_n      = 1'b0;
      case (state)
         IDLE: begin
            baud_cnt_n = '0;
            txd_n      = 1'b1;
            if (en && !fifo.Fempty) begin
               state_n = FETCH;
               ren_n   = 1'b1;
            end
         end
         FETCH: begin
            baud_cnt_n = '0;
            state_n    = LOAD;
         end
         LOAD: begin
            shreg_n    = fifo.Fdata;
            par_n      = ^fifo.Fdata;
            txd_n      = 1'b0;
            baud_cnt_n = '0;
            state_n    = START;
         end
         START:
            if (bit_end) begin
               txd_n     = shreg[0];
               bit_cnt_n = '0;
               state_n   = DATA;
            end
         DATA:
            if (bit_end) begin
               if (bit_cnt == 3'd7) begin
                  state_n = PARITY_EN ? PAR : STOP;
                  txd_n   = PARITY_EN ? par : 1'b1;
               end else begin
                  shreg_n   = shreg >> 1;
                  txd_n     = shreg[1];
                  bit_cnt_n = bit_cnt + 3'd1;
               end
            end
         PAR:
            if (bit_end) begin
               txd_n   = 1'b1;
               state_n = STOP;
            end
         STOP:
            if (bit_end) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: drives two transmitters (parity off/on) from FIFO models and decodes their frames at bit centres.
module tb_fifo_uart_tx;
   localparam int C = 4;
   typedef struct packed {logic [7:0] d; logic p; logic s; logic [31:0] t;} frame_t;
   logic ck = 1'b0, rst = 1'b0, en = 1'b0;
   logic txd0, txd1, busy0, busy1;
   logic [7:0] q0[$], q1[$];
   frame_t rx0[$], rx1[$];
   int cyc = 0, tests = 0, fails = 0, viol = 0;
   int ren_cnt0 = 0, ren_cnt1 = 0, ren_t0 = 0, ren_t1 = 0;
   fifo_uart_tx_if f0 ();
   fifo_uart_tx_if f1 ();
   fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0)) dut0 (
      .ck(ck), .rst(rst), .en(en), .fifo(f0), .txd(txd0), .busy(busy0));
   fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1)) dut1 (
      .ck(ck), .rst(rst), .en(en), .fifo(f1), .txd(txd1), .busy(busy1));
   always #5 ck = ~ck;
   always @(posedge ck) cyc <= cyc + 1;
   // FIFO models: read data one cycle after Ren, registered empty flag
   always @(posedge ck) begin
      if (f0.Ren === 1'b1 && q0.size() != 0) f0.Fdata <= q0.pop_front();
      f0.Fempty <= (q0.size() == 0);
      if (f1.Ren === 1'b1 && q1.size() != 0) f1.Fdata <= q1.pop_front();
      f1.Fempty <= (q1.size() == 0);
   end
   always @(negedge ck) begin
      if (f0.Ren === 1'b1) begin
         ren_cnt0++;
         ren_t0 = cyc;
         if (f0.Fempty === 1'b1) viol++;
      end
      if (f1.Ren === 1'b1) begin
         ren_cnt1++;
         ren_t1 = cyc;
         if (f1.Fempty === 1'b1) viol++;
      end
   end
   task automatic decode(input int d);
      frame_t f;
      forever begin
         @(negedge ck);
         if (rst === 1'b1 && (d == 1 ? txd1 : txd0) === 1'b0) begin
            f = '0;
            f.t = cyc;
            repeat (C / 2) @(negedge ck);
            for (int i = 0; i < 8; i++) begin
               repeat (C) @(negedge ck);
               f.d[i] = d == 1 ? txd1 : txd0;
            end
            if (d == 1) begin
               repeat (C) @(negedge ck);
               f.p = txd1;
            end
            repeat (C) @(negedge ck);
            f.s = d == 1 ? txd1 : txd0;
            if (d == 1) rx1.push_back(f);
            else rx0.push_back(f);
         end
      end
   endtask
   initial decode(0);
   initial decode(1);
   task automatic wait_fall(input int d, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge ck);
         ok = (d == 1 ? txd1 : txd0) === 1'b0;
      end
   endtask
   task automatic wait_rx(input int d, input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge ck);
         ok = d == 1 ? (rx1.size() >= n && busy1 === 1'b0) : (rx0.size() >= n && busy0 === 1'b0);
      end
   endtask
   task automatic test_reset;
      rst = 1'b0;
      en = 1'b1;
      q0.push_back(8'hA5);
      repeat (3) @(negedge ck);
      tests++;
      if (txd0 !== 1'b1 || txd1 !== 1'b1) begin
         fails++;
         $display("FAIL reset_txd: got %b/%b, want 1/1", txd0, txd1);
      end
      tests++;
      if (f0.Ren !== 1'b0 || f1.Ren !== 1'b0) begin
         fails++;
         $display("FAIL reset_ren: got %b/%b, want 0/0", f0.Ren, f1.Ren);
      end
      tests++;
      if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
         fails++;
         $display("FAIL reset_busy: got %b/%b, want 0/0", busy0, busy1);
      end
      tests++;
      if (ren_cnt0 != 0 || ren_cnt1 != 0) begin
         fails++;
         $display("FAIL reset_no_read: got %0d/%0d pulses, want 0/0", ren_cnt0, ren_cnt1);
      end
   endtask
   task automatic test_single;
      logic [9:0] fr;
      int r;
      bit ok;
      fr = {1'b1, 8'hA5, 1'b0};
      r = ren_cnt0;
      rx0.delete();
      rst = 1'b1;
      wait_fall(0, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL single_start: got no start bit, want one");
      end
      tests++;
      if (cyc - ren_t0 != 2) begin
         fails++;
         $display("FAIL single_latency: got %0d, want 2", cyc - ren_t0);
      end
      tests++;
      if (ren_cnt0 - r != 1) begin
         fails++;
         $display("FAIL single_ren: got %0d, want 1", ren_cnt0 - r);
      end
      for (int k = 0; k < 10; k++) begin
         repeat (k == 0 ? C / 2 : C) @(negedge ck);
         tests++;
         if (txd0 !== fr[k]) begin
            fails++;
            $display("FAIL single_bit%0d: got %b, want %b", k, txd0, fr[k]);
         end
      end
      @(negedge ck);
      tests++;
      if (busy0 !== 1'b1) begin
         fails++;
         $display("FAIL single_busy_end: got %b, want 1", busy0);
      end
      @(negedge ck);
      tests++;
      if (busy0 !== 1'b0) begin
         fails++;
         $display("FAIL single_busy_drop: got %b, want 0", busy0);
      end
      repeat (10) @(negedge ck);
      tests++;
      if (txd0 !== 1'b1 || ren_cnt0 - r != 1) begin
         fails++;
         $display("FAIL single_idle: got txd %b reads %0d, want 1 and 1", txd0, ren_cnt0 - r);
      end
      tests++;
      if (rx0.size() != 1 || rx0[0].d !== 8'hA5 || rx0[0].s !== 1'b1) begin
         fails++;
         $display("FAIL single_decode: got %0d frames %h, want 1 frame a5", rx0.size(), rx0[0].d);
      end
   endtask
   task automatic test_parity;
      logic [7:0] a, b;
      int r;
      bit ok;
      a = 8'h01;
      b = 8'h03;
      r = ren_cnt1;
      rx1.delete();
      q1.push_back(a);
      q1.push_back(b);
      wait_rx(1, 2, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL parity_timeout: got %0d frames, want 2", rx1.size());
      end
      tests++;
      if (rx1[0].d !== a || rx1[0].p !== ^a || rx1[0].s !== 1'b1) begin
         fails++;
         $display("FAIL parity_frame0: got d %h p %b s %b, want %h %b 1", rx1[0].d, rx1[0].p, rx1[0].s, a, ^a);
      end
      tests++;
      if (rx1[1].d !== b || rx1[1].p !== ^b || rx1[1].s !== 1'b1) begin
         fails++;
         $display("FAIL parity_frame1: got d %h p %b s %b, want %h %b 1", rx1[1].d, rx1[1].p, rx1[1].s, b, ^b);
      end
      tests++;
      if (rx1[1].t - rx1[0].t != 32'((10 + 1) * C + 3)) begin
         fails++;
         $display("FAIL parity_gap: got %0d, want %0d", rx1[1].t - rx1[0].t, (10 + 1) * C + 3);
      end
      tests++;
      if (ren_cnt1 - r != 2) begin
         fails++;
         $display("FAIL parity_ren: got %0d, want 2", ren_cnt1 - r);
      end
   endtask
   task automatic test_back_to_back;
      int r0, r1;
      bit ok0, ok1;
      rx0.delete();
      rx1.delete();
      en = 1'b0;
      for (int i = 0; i < 16; i++) begin
         q0.push_back(8'(i));
         q1.push_back(8'(i));
      end
      repeat (3) @(negedge ck);
      r0 = ren_cnt0;
      r1 = ren_cnt1;
      en = 1'b1;
      wait_rx(0, 16, ok0);
      wait_rx(1, 16, ok1);
      tests++;
      if (!ok0 || !ok1) begin
         fails++;
         $display("FAIL b2b_timeout: got %0d/%0d frames, want 16/16", rx0.size(), rx1.size());
      end
      for (int i = 0; i < 16; i++) begin
         tests++;
         if (rx0[i].d !== 8'(i) || rx0[i].s !== 1'b1 || rx1[i].d !== 8'(i) || rx1[i].p !== ^8'(i) || rx1[i].s !== 1'b1) begin
            fails++;
            $display("FAIL b2b_frame%0d: got %h/%h p %b, want %h p %b", i, rx0[i].d, rx1[i].d, rx1[i].p, 8'(i), ^8'(i));
         end
      end
      tests++;
      if (ren_cnt0 - r0 != 16 || ren_cnt1 - r1 != 16) begin
         fails++;
         $display("FAIL b2b_ren: got %0d/%0d, want 16/16", ren_cnt0 - r0, ren_cnt1 - r1);
      end
      tests++;
      if (viol != 0) begin
         fails++;
         $display("FAIL ren_while_empty: got %0d, want 0", viol);
      end
   endtask
   task automatic test_en_pause;
      int r, k;
      bit ok;
      rx0.delete();
      r = ren_cnt0;
      q0.push_back(8'h3C);
      q0.push_back(8'h5A);
      wait_fall(0, ok);
      repeat (3 * C) @(negedge ck);
      en = 1'b0;
      wait_rx(0, 1, ok);
      repeat (20) @(negedge ck);
      tests++;
      if (ren_cnt0 - r != 1 || rx0.size() != 1 || rx0[0].d !== 8'h3C) begin
         fails++;
         $display("FAIL pause_hold: got reads %0d frames %0d d %h, want 1 1 3c", ren_cnt0 - r, rx0.size(), rx0[0].d);
      end
      en = 1'b1;
      k = cyc;
      wait_fall(0, ok);
      tests++;
      if (!ok || cyc - k != 3) begin
         fails++;
         $display("FAIL pause_resume: got start %0d cycles after en, want 3", cyc - k);
      end
      wait_rx(0, 2, ok);
      tests++;
      if (rx0[1].d !== 8'h5A || ren_cnt0 - r != 2) begin
         fails++;
         $display("FAIL pause_next: got %h reads %0d, want 5a 2", rx0[1].d, ren_cnt0 - r);
      end
   endtask
   task automatic test_reset_mid;
      int r;
      bit ok;
      q0.push_back(8'h96);
      wait_fall(0, ok);
      repeat (3 * C + 1) @(negedge ck);
      rst = 1'b0;
      r = ren_cnt0;
      @(negedge ck);
      tests++;
      if (txd0 !== 1'b1 || busy0 !== 1'b0) begin
         fails++;
         $display("FAIL midreset_state: got txd %b busy %b, want 1 0", txd0, busy0);
      end
      rst = 1'b1;
      repeat (60) @(negedge ck);
      tests++;
      if (ren_cnt0 != r || txd0 !== 1'b1) begin
         fails++;
         $display("FAIL midreset_quiet: got reads %0d txd %b, want 0 1", ren_cnt0 - r, txd0);
      end
      rx0.delete();
      q0.push_back(8'hC3);
      wait_fall(0, ok);
      tests++;
      if (!ok || cyc - ren_t0 != 2 || ren_cnt0 - r != 1) begin
         fails++;
         $display("FAIL midreset_fetch: got latency %0d reads %0d, want 2 1", cyc - ren_t0, ren_cnt0 - r);
      end
      wait_rx(0, 1, ok);
      tests++;
      if (rx0.size() != 1 || rx0[0].d !== 8'hC3 || rx0[0].s !== 1'b1) begin
         fails++;
         $display("FAIL midreset_frame: got %0d frames %h, want 1 frame c3", rx0.size(), rx0[0].d);
      end
   endtask
   task automatic test_random;
      logic [7:0] exp[$];
      logic [7:0] v;
      int r0, r1;
      bit ok0, ok1;
      rx0.delete();
      rx1.delete();
      r0 = ren_cnt0;
      r1 = ren_cnt1;
      for (int i = 0; i < 8; i++) begin
         v = 8'($urandom);
         exp.push_back(v);
         q0.push_back(v);
         q1.push_back(v);
         repeat ($urandom_range(0, 50)) @(negedge ck);
         if ($urandom_range(0, 3) == 0) begin
            en = 1'b0;
            repeat ($urandom_range(1, 40)) @(negedge ck);
            en = 1'b1;
         end
      end
      wait_rx(0, 8, ok0);
      wait_rx(1, 8, ok1);
      tests++;
      if (!ok0 || !ok1 || rx0.size() != 8 || rx1.size() != 8) begin
         fails++;
         $display("FAIL rand_count: got %0d/%0d frames, want 8/8", rx0.size(), rx1.size());
      end
      for (int i = 0; i < 8; i++) begin
         tests++;
         if (rx0[i].d !== exp[i] || rx1[i].d !== exp[i] || rx1[i].p !== ^exp[i] || rx0[i].s !== 1'b1 || rx1[i].s !== 1'b1) begin
            fails++;
            $display("FAIL rand_frame%0d: got %h/%h p %b, want %h p %b", i, rx0[i].d, rx1[i].d, rx1[i].p, exp[i], ^exp[i]);
         end
      end
      tests++;
      if (ren_cnt0 - r0 != 8 || ren_cnt1 - r1 != 8 || viol != 0) begin
         fails++;
         $display("FAIL rand_ren: got %0d/%0d reads %0d underflows, want 8/8 0", ren_cnt0 - r0, ren_cnt1 - r1, viol);
      end
   endtask
   initial begin
      @(negedge ck);
      test_reset;
      test_single;
      test_parity;
      test_back_to_back;
      test_en_pause;
      test_reset_mid;
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, want summary");
      $fatal(1);
   end
endmodule
